// File: rtl/alu_issue_ctrl.sv
// Issue/capture front end for the combinational ALU: decodes ALUOp/funct, registers operands
// and control, captures the result and hands it off. Optional macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           alu_op,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [WIDTH-1:0]     alu_left,
    output logic [WIDTH-1:0]     alu_right,
    output logic [3:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] op_count
);

    // state    | meaning
    // IDLE     | ready for a request; accepting latches operands and control code
    // ISSUE    | ALU inputs stable; result captured on the next edge
    // CAPTURE  | result valid, held until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     alu_left_q, alu_left_d;
    logic [WIDTH-1:0]     alu_right_q, alu_right_d;
    logic [3:0]           alu_control_q, alu_control_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
    logic [3:0]           dec_code;

    // Illegal encodings fall through to add; the trap build overrides the result later.
    always_comb begin
        dec_code = CTRL_ADD;
        case (alu_op)
            2'b01: dec_code = CTRL_SUB;
            2'b10: begin
                case (funct)
                    6'b100010: dec_code = CTRL_SUB;
                    6'b100100: dec_code = CTRL_AND;
                    6'b100101: dec_code = CTRL_OR;
                    6'b101010: dec_code = CTRL_SLT;
                    6'b100111: dec_code = CTRL_NOR;
                    default:   dec_code = CTRL_ADD;
                endcase
            end
            default: dec_code = CTRL_ADD;
        endcase
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic dec_illegal;
    logic illegal_pend_q, illegal_pend_d;
    logic illegal_q, illegal_d;

    always_comb begin
        dec_illegal = 1'b0;
        if (alu_op == 2'b11) begin
            dec_illegal = 1'b1;
        end else if (alu_op == 2'b10) begin
            case (funct)
                6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010, 6'b100111: dec_illegal = 1'b0;
                default:                         dec_illegal = 1'b1;
            endcase
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        alu_left_d    = alu_left_q;
        alu_right_d   = alu_right_q;
        alu_control_d = alu_control_q;
        result_d      = result_q;
        zero_d        = zero_q;
        out_valid_d   = out_valid_q;
        op_count_d    = op_count_q;
        in_ready      = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        illegal_pend_d = illegal_pend_q;
        illegal_d      = illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    alu_left_d    = op_a;
                    alu_right_d   = op_b;
                    alu_control_d = dec_code;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    illegal_pend_d = dec_illegal;
`endif
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                result_d    = alu_result;
                zero_d      = (alu_result == '0);
                out_valid_d = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                if (illegal_pend_q) begin
                    result_d  = '0;
                    zero_d    = 1'b1;
                    illegal_d = 1'b1;
                end
`endif
                state_d     = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    illegal_d   = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            alu_left_q    <= '0;
            alu_right_q   <= '0;
            alu_control_q <= CTRL_ADD;
            result_q      <= '0;
            zero_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            alu_left_q    <= alu_left_d;
            alu_right_q   <= alu_right_d;
            alu_control_q <= alu_control_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            out_valid_q   <= out_valid_d;
            op_count_q    <= op_count_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_pend_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            illegal_pend_q <= illegal_pend_d;
            illegal_q      <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign alu_left    = alu_left_q;
    assign alu_right   = alu_right_q;
    assign alu_control = alu_control_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign out_valid   = out_valid_q;
    assign op_count    = op_count_q;

endmodule
